// File: rtl/router_pkt_tx_if.sv
// Handshake and data bundle between a packet source, the transmitter and the router input port.
// The transmitter takes the master side; the environment or upstream logic takes the slave side.
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] start_addr;
  logic [5:0] start_len;
  logic       corrupt_parity;
  logic       start_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       done;
  logic       err_flag;
  logic       bad_req;

  modport master (
    input  start, start_addr, start_len, corrupt_parity,
    input  pl_data, pl_valid, busy, err,
    output start_ready, pl_ready, pkt_valid, data_out, done, err_flag, bad_req
  );

  modport slave (
    output start, start_addr, start_len, corrupt_parity,
    output pl_data, pl_valid, busy, err,
    input  start_ready, pl_ready, pkt_valid, data_out, done, err_flag, bad_req
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Store-and-forward packet transmitter: buffers a payload, then streams header, payload
// and parity into the router with no gaps, and reports the router error status per packet.
module router_pkt_tx #(
  parameter int MAX_LEN  = 63,
  parameter int ERR_WAIT = 3
) (
  input  logic              clock,
  input  logic              resetn,
  router_pkt_tx_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HEADER,
    PAYLOAD,
    PARITY,
    ERRWAIT
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d;
  logic       corrupt_q, corrupt_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] idx_q, idx_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] data_q, data_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic       err_flag_q, err_flag_d;
  logic       done_q, done_d;
  logic       bad_req_q, bad_req_d;
  logic       wr_en;

  logic [7:0] buffer [MAX_LEN];

  assign bus.start_ready = (state_q == IDLE);
  assign bus.pl_ready    = (state_q == LOAD);
  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.data_out    = data_q;
  assign bus.done        = done_q;
  assign bus.err_flag    = err_flag_q;
  assign bus.bad_req     = bad_req_q;

  // Payload storage is not reset; only the indices matter between packets.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      buffer[idx_q] <= bus.pl_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q     <= IDLE;
      addr_q      <= 2'd0;
      len_q       <= 6'd0;
      corrupt_q   <= 1'b0;
      parity_q    <= 8'd0;
      idx_q       <= 6'd0;
      wait_q      <= 8'd0;
      data_q      <= 8'd0;
      pkt_valid_q <= 1'b0;
      err_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      bad_req_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      corrupt_q   <= corrupt_d;
      parity_q    <= parity_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      data_q      <= data_d;
      pkt_valid_q <= pkt_valid_d;
      err_flag_q  <= err_flag_d;
      done_q      <= done_d;
      bad_req_q   <= bad_req_d;
    end
  end

  // Each output beat is loaded into data_q on the edge that enters its state or accepts the previous beat.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    corrupt_d   = corrupt_q;
    parity_d    = parity_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    data_d      = data_q;
    pkt_valid_d = pkt_valid_q;
    err_flag_d  = err_flag_q;
    done_d      = 1'b0;
    bad_req_d   = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.start_addr == 2'd3 || bus.start_len == 6'd0) begin
            bad_req_d = 1'b1;
          end else begin
            addr_d     = bus.start_addr;
            len_d      = bus.start_len;
            corrupt_d  = bus.corrupt_parity;
            parity_d   = {bus.start_len, bus.start_addr};
            idx_d      = 6'd0;
            err_flag_d = 1'b0;
            state_d    = LOAD;
          end
        end
      end
      LOAD: begin
        if (bus.pl_valid) begin
          wr_en    = 1'b1;
          parity_d = parity_q ^ bus.pl_data;
          if (idx_q == len_q - 6'd1) begin
            idx_d       = 6'd0;
            data_d      = {len_q, addr_q};
            pkt_valid_d = 1'b1;
            state_d     = HEADER;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
      end
      HEADER: begin
        if (!bus.busy) begin
          data_d  = buffer[6'd0];
          idx_d   = 6'd0;
          state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (!bus.busy) begin
          if (idx_q == len_q - 6'd1) begin
            data_d      = corrupt_q ? ~parity_q : parity_q;
            pkt_valid_d = 1'b0;
            state_d     = PARITY;
          end else begin
            idx_d  = idx_q + 6'd1;
            data_d = buffer[idx_q + 6'd1];
          end
        end
      end
      PARITY: begin
        if (!bus.busy) begin
          data_d  = 8'd0;
          wait_d  = 8'd0;
          state_d = ERRWAIT;
        end
      end
      ERRWAIT: begin
        err_flag_d = err_flag_q | bus.err;
        if (wait_q == 8'(ERR_WAIT - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: a cycle task models the router (busy, err) and
// compares every presented beat and every done status against queued expectations.
module tb_router_pkt_tx;

  logic clock;
  logic resetn;

  router_pkt_tx_if bus();

  router_pkt_tx #(.MAX_LEN(63), .ERR_WAIT(3)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [8:0] exp_q[$];
  logic       exp_err[$];
  int         beat_q[$];
  bit         in_pkt;
  int         beats;
  int         busy_cnt;
  int         err_delay;
  int         done_cnt;
  bit         rand_busy;
  bit         rand_gaps;
  bit         hdr_stall;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: advance to the falling edge, then act as the router for the next rising edge.
  task automatic tick();
    logic [8:0] e;
    @(negedge clock);
    if (!resetn) begin
      exp_q.delete();
      exp_err.delete();
      beat_q.delete();
      in_pkt    = 1'b0;
      beats     = 0;
      busy_cnt  = 0;
      err_delay = 0;
      bus.busy  = 1'b0;
      bus.err   = 1'b0;
      return;
    end
    if (busy_cnt > 0) begin
      bus.busy = 1'b1;
      busy_cnt--;
    end else begin
      bus.busy = rand_busy && ($urandom_range(0, 2) == 0);
    end
    if (err_delay > 0) begin
      err_delay--;
      if (err_delay == 0) bus.err = 1'b1;
    end
    if (bus.done) begin
      done_cnt++;
      if (exp_err.size() > 0) checkOutput("err_flag", bus.err_flag, exp_err.pop_front());
      else checkOutput("spurious_done", 1, 0);
      bus.err = 1'b0;
    end
    if (bus.pkt_valid || in_pkt) begin
      if (exp_q.size() == 0) begin
        checkOutput("extra_beat", 1, 0);
      end else begin
        e = exp_q[0];
        checkOutput(e[8] ? "parity_byte" : "data_byte", bus.data_out, e[7:0]);
        checkOutput("pkt_valid", bus.pkt_valid, !e[8]);
        if (!bus.busy) begin
          void'(exp_q.pop_front());
          beats++;
          if (e[8]) begin
            in_pkt = 1'b0;
            if (beat_q.size() > 0) checkOutput("beat_count", beats, beat_q.pop_front());
            if (exp_err.size() > 0 && exp_err[0]) err_delay = 2;
            beats = 0;
          end else begin
            in_pkt = 1'b1;
            if (beats == 1 && hdr_stall) busy_cnt = 2;
          end
        end
      end
    end
  endtask

  // Requests one packet, queues its expected beats and status, then streams the payload in.
  task automatic applyStimulus(input logic [1:0] a, input logic [5:0] l, input bit corrupt,
                               input bit fixed, input bit want_err);
    logic [7:0] pl[$];
    logic [7:0] par;
    logic [7:0] b;
    int guard;
    int i;
    guard = 0;
    while (!bus.start_ready && guard < 500) begin
      tick();
      guard++;
    end
    checkOutput("start_ready_wait", bus.start_ready, 1);
    par = {l, a};
    exp_q.push_back({1'b0, l, a});
    for (int k = 0; k < int'(l); k++) begin
      b = fixed ? 8'(8'h11 * (k + 1)) : 8'($urandom);
      pl.push_back(b);
      par = par ^ b;
      exp_q.push_back({1'b0, b});
    end
    exp_q.push_back({1'b1, corrupt ? ~par : par});
    exp_err.push_back(want_err);
    beat_q.push_back(int'(l) + 2);
    bus.start          = 1'b1;
    bus.start_addr     = a;
    bus.start_len      = l;
    bus.corrupt_parity = corrupt;
    tick();
    bus.start          = 1'b0;
    bus.corrupt_parity = 1'b0;
    checkOutput("err_flag_cleared", bus.err_flag, 0);
    i = 0;
    guard = 0;
    while (i < int'(l) && guard < 5000) begin
      if (rand_gaps && $urandom_range(0, 2) == 0) begin
        bus.pl_valid = 1'b0;
      end else begin
        bus.pl_valid = 1'b1;
        bus.pl_data  = pl[i];
        if (bus.pl_ready) i++;
      end
      tick();
      guard++;
    end
    bus.pl_valid = 1'b0;
    checkOutput("load_complete", i, int'(l));
    checkOutput("pl_ready_off", bus.pl_ready, 0);
  endtask

  task automatic waitDone();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp_err.size() != 0) && guard < 3000) begin
      tick();
      guard++;
    end
    checkOutput("packet_timeout", exp_q.size() + exp_err.size(), 0);
  endtask

  task automatic badRequest(input logic [1:0] a, input logic [5:0] l);
    bus.start      = 1'b1;
    bus.start_addr = a;
    bus.start_len  = l;
    tick();
    bus.start = 1'b0;
    checkOutput("bad_req_pulse", bus.bad_req, 1);
    checkOutput("bad_start_ready", bus.start_ready, 1);
    checkOutput("bad_pkt_valid", bus.pkt_valid, 0);
    tick();
    checkOutput("bad_req_end", bus.bad_req, 0);
    checkOutput("bad_pl_ready", bus.pl_ready, 0);
  endtask

  initial begin
    int guard;
    int snap;
    resetn             = 1'b0;
    bus.start          = 1'b0;
    bus.start_addr     = 2'd0;
    bus.start_len      = 6'd0;
    bus.corrupt_parity = 1'b0;
    bus.pl_data        = 8'd0;
    bus.pl_valid       = 1'b0;
    bus.busy           = 1'b0;
    bus.err            = 1'b0;
    in_pkt = 1'b0; beats = 0; busy_cnt = 0; err_delay = 0; done_cnt = 0;
    rand_busy = 1'b0; rand_gaps = 1'b0; hdr_stall = 1'b0;

    repeat (3) tick();
    checkOutput("rst_pkt_valid", bus.pkt_valid, 0);
    checkOutput("rst_data_out", bus.data_out, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_err_flag", bus.err_flag, 0);
    checkOutput("rst_bad_req", bus.bad_req, 0);
    checkOutput("rst_pl_ready", bus.pl_ready, 0);
    checkOutput("rst_start_ready", bus.start_ready, 1);
    resetn = 1'b1;
    tick();

    $display("[TB] basic packet addr=1 len=3");
    applyStimulus(2'd1, 6'd3, 1'b0, 1'b1, 1'b0);
    waitDone();

    $display("[TB] router busy after header");
    hdr_stall = 1'b1;
    applyStimulus(2'd1, 6'd3, 1'b0, 1'b1, 1'b0);
    waitDone();
    hdr_stall = 1'b0;

    $display("[TB] illegal requests");
    badRequest(2'd3, 6'd5);
    badRequest(2'd0, 6'd0);

    $display("[TB] corrupted parity with router err");
    applyStimulus(2'd1, 6'd3, 1'b1, 1'b1, 1'b1);
    waitDone();

    $display("[TB] max length with payload gaps");
    rand_gaps = 1'b1;
    applyStimulus(2'd2, 6'd63, 1'b0, 1'b0, 1'b0);
    waitDone();
    rand_gaps = 1'b0;

    $display("[TB] single byte and random busy");
    applyStimulus(2'd0, 6'd1, 1'b0, 1'b0, 1'b0);
    waitDone();
    rand_busy = 1'b1;
    applyStimulus(2'd2, 6'd17, 1'b0, 1'b0, 1'b0);
    waitDone();
    rand_busy = 1'b0;

    $display("[TB] reset during payload");
    applyStimulus(2'd2, 6'd20, 1'b0, 1'b0, 1'b0);
    guard = 0;
    while (!(in_pkt && beats >= 3) && guard < 200) begin
      tick();
      guard++;
    end
    checkOutput("reach_payload", beats >= 3, 1);
    resetn = 1'b0;
    tick();
    checkOutput("abort_pkt_valid", bus.pkt_valid, 0);
    checkOutput("abort_data_out", bus.data_out, 0);
    checkOutput("abort_start_ready", bus.start_ready, 1);
    checkOutput("abort_done", bus.done, 0);
    resetn = 1'b1;
    snap = done_cnt;
    repeat (10) tick();
    checkOutput("no_done_after_abort", done_cnt, snap);
    applyStimulus(2'd1, 6'd3, 1'b0, 1'b1, 1'b0);
    waitDone();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
